// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared state encoding, error width and march pattern for the memory BIST
package mem_bist_pkg;
  typedef enum logic [2:0] {IDLE, WR_UP, RD_UP, WR_DN, RD_DN, DRAIN, DONE} state_t;
  localparam int ERR_W = 8;
  function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] a);
    return seed ^ a;
  endfunction
endpackage

// File: rtl/mem_bist_if.sv
// mem_bist_if: single-port synchronous memory bus between the BIST initiator and the memory
interface mem_bist_if #(parameter int ADDR_W = 4, parameter int DATA_W = 8);
  logic [ADDR_W-1:0] add;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              we;
  modport master(output add, data_in, we, input data_out);
  modport slave(input add, data_in, we, output data_out);
endinterface

// File: rtl/mem_bist_rdpipe.sv
// mem_bist_rdpipe: RD_LAT-deep delay line aligning {valid, addr, exp} with the memory read data
module mem_bist_rdpipe #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_v,
  input  logic [ADDR_W-1:0] d_a,
  input  logic [DATA_W-1:0] d_e,
  output logic              q_v,
  output logic [ADDR_W-1:0] q_a,
  output logic [DATA_W-1:0] q_e
);
  localparam int W = 1 + ADDR_W + DATA_W;
  logic [W-1:0] stg [RD_LAT];
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < RD_LAT; i++) stg[i] <= '0;
    else begin
      stg[0] <= {d_v, d_a, d_e};
      for (int i = 1; i < RD_LAT; i++) stg[i] <= stg[i-1];
    end
  assign {q_v, q_a, q_e} = stg[RD_LAT-1];
endmodule

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: 4-phase march BIST initiator with saturating error count and first-failure capture
module mem_bist_ctrl import mem_bist_pkg::*; #(
  parameter int              ADDR_W = 4,
  parameter int              DATA_W = 8,
  parameter int              RD_LAT = 1,
  parameter logic [DATA_W-1:0] SEED = DATA_W'('hA5)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_exp,
  mem_bist_if.master        mem
);
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] add_d, chk_a;
  logic [DATA_W-1:0] din_d, chk_e, rd_exp;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_d, go, rd, chk_v, mis;
  function automatic logic [DATA_W-1:0] p(input logic [ADDR_W-1:0] a);
    return DATA_W'(pat(32'(SEED), 32'(a)));
  endfunction
  assign go     = start && (state_q == IDLE || state_q == DONE);
  assign rd     = state_q == RD_UP || state_q == RD_DN;
  assign rd_exp = state_q == RD_UP ? p(mem.add) : ~p(mem.add);
  assign busy   = state_q != IDLE && state_q != DONE;
  assign done   = state_q == DONE;
  assign pass   = done && err_count == '0;
  always_comb begin
    state_d = state_q;
    add_d   = mem.add;
    din_d   = mem.data_in;
    we_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = WR_UP;
        add_d   = '0;
        din_d   = p('0);
        we_d    = 1'b1;
      end
      WR_UP: begin
        add_d   = mem.add + 1'b1;
        din_d   = p(add_d);
        we_d    = mem.add != LAST;
        state_d = mem.add == LAST ? RD_UP : WR_UP;
      end
      RD_UP: begin
        add_d   = mem.add == LAST ? LAST : mem.add + 1'b1;
        din_d   = mem.add == LAST ? ~p(LAST) : mem.data_in;
        we_d    = mem.add == LAST;
        state_d = mem.add == LAST ? WR_DN : RD_UP;
      end
      WR_DN: begin
        add_d   = mem.add - 1'b1;
        din_d   = ~p(add_d);
        we_d    = mem.add != '0;
        state_d = mem.add == '0 ? RD_DN : WR_DN;
      end
      RD_DN: begin
        add_d   = mem.add == '0 ? mem.add : mem.add - 1'b1;
        cnt_d   = CW'(RD_LAT - 1);
        state_d = mem.add == '0 ? DRAIN : RD_DN;
      end
      DRAIN: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= IDLE;
      mem.add     <= '0;
      mem.data_in <= '0;
      mem.we      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem.add     <= add_d;
      mem.data_in <= din_d;
      mem.we      <= we_d;
      cnt_q       <= cnt_d;
    end
  mem_bist_rdpipe #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rdpipe (
    .clk(clk), .rst(rst),
    .d_v(rd), .d_a(mem.add), .d_e(rd_exp),
    .q_v(chk_v), .q_a(chk_a), .q_e(chk_e)
  );
  assign mis = chk_v && mem.data_out != chk_e;
  // only the first mismatch of a run is captured, identified by the count still being zero
  always_ff @(posedge clk)
    if (rst || go) begin
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_exp  <= '0;
    end else if (mis) begin
      err_count <= err_count + ERR_W'(err_count != '1);
      if (err_count == '0) begin
        fail_addr <= chk_a;
        fail_data <= mem.data_out;
        fail_exp  <= chk_e;
      end
    end
endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb_mem_bist_ctrl: randomized fault-injection bench for RD_LAT=1 and RD_LAT=3 instances against a march model
module tb_mem_bist_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int D  = 16;
  localparam logic [7:0] SEED = 8'hA5;
  logic clk = 0, rst = 1, start = 0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int fmode = 0;
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_mask = '0, f_val = '0;
  logic [7:0] exp_err;
  logic [AW-1:0] exp_fa;
  logic [DW-1:0] exp_fd, exp_fe;
  logic [11:0] exp_wr [$];
  logic [11:0] q1 [$];
  logic [11:0] q3 [$];
  mem_bist_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();
  mem_bist_if #(.ADDR_W(AW), .DATA_W(DW)) m3 ();
  logic busy1, done1, pass1, busy3, done3, pass3;
  logic [7:0] err1, err3;
  logic [AW-1:0] fa1, fa3;
  logic [DW-1:0] fd1, fe1, fd3, fe3;
  mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .SEED(SEED)) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_addr(fa1), .fail_data(fd1), .fail_exp(fe1), .mem(m1));
  mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .SEED(SEED)) dut3 (
    .clk(clk), .rst(rst), .start(start), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_addr(fa3), .fail_data(fd3), .fail_exp(fe3), .mem(m3));
  function automatic logic [7:0] pt(input int a);
    return SEED ^ 8'(a);
  endfunction
  function automatic logic [7:0] fwr(input logic [AW-1:0] a, input logic [7:0] d);
    return (fmode == 1 && a == f_addr) ? ((d & ~f_mask) | (f_val & f_mask)) : d;
  endfunction
  logic [7:0] mem1 [D];
  logic [7:0] mem3 [D];
  logic [7:0] r1 = 0, r3a = 0, r3b = 0, r3c = 0;
  always @(posedge clk) begin
    if (m1.we) mem1[m1.add] <= fwr(m1.add, m1.data_in);
    if (m3.we) mem3[m3.add] <= fwr(m3.add, m3.data_in);
    r1  <= mem1[m1.add];
    r3a <= mem3[m3.add];
    r3b <= r3a;
    r3c <= r3b;
  end
  assign m1.data_out = fmode == 2 ? 8'h00 : r1;
  assign m3.data_out = fmode == 2 ? 8'h00 : r3c;
  always @(negedge clk) begin
    if (m1.we) q1.push_back({m1.add, m1.data_in});
    if (m3.we) q3.push_back({m3.add, m3.data_in});
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_model();
    logic [7:0] st [D];
    int e;
    logic [7:0] x, o;
    int a;
    e = 0;
    exp_fa = '0; exp_fd = '0; exp_fe = '0;
    exp_wr.delete();
    for (int ph = 0; ph < 4; ph++)
      for (int i = 0; i < D; i++) begin
        a = ph < 2 ? i : D - 1 - i;
        x = ph < 2 ? pt(a) : ~pt(a);
        if (ph % 2 == 0) begin
          exp_wr.push_back({4'(a), x});
          st[a] = fwr(4'(a), x);
        end else begin
          o = fmode == 2 ? 8'h00 : st[a];
          if (o != x) begin
            if (e == 0) begin exp_fa = 4'(a); exp_fd = o; exp_fe = x; end
            if (e < 255) e++;
          end
        end
      end
    exp_err = 8'(e);
  endtask
  task automatic run_test(input bit mid);
    int n, d1, d3, b1, b3;
    run_model();
    b1 = q1.size();
    b3 = q3.size();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    n = 1;
    check("busy_c1", {busy1, busy3}, 2'b11);
    check("done_clr", {done1, done3}, 2'b00);
    check("res_clr", {err1, fa1, fd1, fe1, err3, fa3, fd3, fe3}, 0);
    d1 = 0;
    d3 = 0;
    while ((d1 == 0 || d3 == 0) && n < 200) begin
      start = mid && n == 30;
      if (done1 && d1 == 0) d1 = n;
      if (done3 && d3 == 0) d3 = n;
      @(negedge clk);
      n++;
    end
    start = 0;
    check("done_cyc1", d1, 4 * D + 2);
    check("done_cyc3", d3, 4 * D + 4);
    check("err1", err1, exp_err);
    check("err3", err3, exp_err);
    check("pass1", pass1, exp_err == 0);
    check("pass3", pass3, exp_err == 0);
    check("fail1", {fa1, fd1, fe1}, {exp_fa, exp_fd, exp_fe});
    check("fail3", {fa3, fd3, fe3}, {exp_fa, exp_fd, exp_fe});
    check("wr_cnt1", q1.size() - b1, 2 * D);
    check("wr_cnt3", q3.size() - b3, 2 * D);
    for (int i = 0; i < 2 * D; i++) begin
      if (b1 + i < q1.size()) check("wr1", q1[b1+i], exp_wr[i]);
      if (b3 + i < q3.size()) check("wr3", q3[b3+i], exp_wr[i]);
    end
  endtask
  task automatic reset_mid();
    int b1, b3;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (19) @(negedge clk);
    check("busy_c20", {busy1, busy3}, 2'b11);
    rst = 1;
    @(negedge clk);
    check("abort1", {m1.we, busy1, done1, pass1, err1, fa1, fd1, fe1, m1.add, m1.data_in}, 0);
    check("abort3", {m3.we, busy3, done3, pass3, err3, fa3, fd3, fe3, m3.add, m3.data_in}, 0);
    rst = 0;
    #1;
    b1 = q1.size();
    b3 = q3.size();
    repeat (5) @(negedge clk);
    #1;
    check("no_wr", (q1.size() - b1) + (q3.size() - b3), 0);
  endtask
  initial begin
    for (int i = 0; i < D; i++) begin mem1[i] = 0; mem3[i] = 0; end
    repeat (3) @(negedge clk);
    check("rst1", {m1.we, busy1, done1, pass1, err1, fa1, fd1, fe1, m1.add, m1.data_in}, 0);
    check("rst3", {m3.we, busy3, done3, pass3, err3, fa3, fd3, fe3, m3.add, m3.data_in}, 0);
    rst = 0;
    @(negedge clk);
    fmode = 0;
    run_test(0);
    fmode = 1; f_addr = 5; f_mask = 8'h01; f_val = 8'h01;
    run_test(1);
    check("sa1_addr5", {fa1, fd1, fe1, err1}, {4'd5, 8'hA1, 8'hA0, 8'd1});
    fmode = 2;
    run_test(0);
    check("zero_out", {err1, fa1, fe1}, {8'd32, 4'd0, 8'hA5});
    fmode = 0;
    reset_mid();
    run_test(0);
    repeat (8) begin
      fmode  = $urandom_range(0, 2);
      f_addr = 4'($urandom_range(0, D - 1));
      f_mask = 8'(1 << $urandom_range(0, 7)) | 8'($urandom_range(0, 1) << $urandom_range(0, 7));
      f_val  = 8'($urandom);
      run_test(1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
